// File: rtl/rc4_encryptor.sv
// RC4 encryptor core: key schedule (KSA) and keystream generation (PRGA) on an
// external single-port 256x8 S RAM. Plaintext comes from an external ROM and
// ciphertext goes to an external RAM. All memories have 1-cycle read latency.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   start, key        run request (sampled in IDLE) and key, byte 0 in the MSBs
//   sAddr/sIn/sWren   S RAM address / write data / write enable; sOut read data
//   pAddr/pOut        plaintext ROM address / read data
//   cAddr/cIn/cWren   ciphertext RAM address / write data / write enable
//   busy, done        run in progress; one-cycle completion pulse
module rc4_encryptor #(
  parameter int unsigned RAM_WIDTH          = 8,
  parameter int unsigned RAM_LENGTH         = 8,
  parameter int unsigned KEY_LENGTH         = 3,
  parameter int unsigned MESSAGE_LENGTH     = 32,
  parameter int unsigned MESSAGE_LOG_LENGTH = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0]    key,
  output logic [RAM_LENGTH-1:0]              sAddr,
  output logic [RAM_WIDTH-1:0]               sIn,
  output logic                               sWren,
  input  logic [RAM_WIDTH-1:0]               sOut,
  output logic [MESSAGE_LOG_LENGTH-1:0]      pAddr,
  input  logic [RAM_WIDTH-1:0]               pOut,
  output logic [MESSAGE_LOG_LENGTH-1:0]      cAddr,
  output logic [RAM_WIDTH-1:0]               cIn,
  output logic                               cWren,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned KW  = KEY_LENGTH * RAM_WIDTH;
  localparam int unsigned KIW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam int unsigned KCW = MESSAGE_LOG_LENGTH + 1;
  localparam int unsigned PW  = 4;
  localparam logic [PW-1:0] KSA_LAST  = PW'(5);
  localparam logic [PW-1:0] PRGA_LAST = PW'(8);

  typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, FIN} state_t;

  state_t                        state_q, state_d;
  logic [KW-1:0]                 key_q, key_d;
  logic [RAM_LENGTH-1:0]         i_q, i_d, j_q, j_d;
  logic [KCW-1:0]                k_q, k_d;
  logic [KIW-1:0]                kidx_q, kidx_d;
  logic [PW-1:0]                 ph_q, ph_d;
  logic [RAM_WIDTH-1:0]          si_q, si_d, sj_q, sj_d;
  logic [RAM_LENGTH-1:0]         saddr_q, saddr_d;
  logic [RAM_WIDTH-1:0]          sin_q, sin_d;
  logic                          swren_q, swren_d;
  logic [MESSAGE_LOG_LENGTH-1:0] paddr_q, paddr_d, caddr_q, caddr_d;
  logic [RAM_WIDTH-1:0]          cin_q, cin_d;
  logic                          cwren_q, cwren_d;
  logic                          busy_q, busy_d, done_q, done_d;
  logic [RAM_WIDTH-1:0]          key_byte_c;
  logic [RAM_LENGTH-1:0]         j_ksa_c, j_prga_c;

  // key byte selected by the running i mod KEY_LENGTH counter
  always_comb begin
    key_byte_c = '0;
    for (int unsigned b = 0; b < KEY_LENGTH; b++) begin
      if (kidx_q == KIW'(b)) key_byte_c = key_q[KW-1-b*RAM_WIDTH -: RAM_WIDTH];
    end
  end

  assign j_ksa_c  = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte_c);
  assign j_prga_c = j_q + RAM_LENGTH'(sOut);

  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      kidx_q  <= '0;
      ph_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      saddr_q <= '0;
      sin_q   <= '0;
      swren_q <= 1'b0;
      paddr_q <= '0;
      caddr_q <= '0;
      cin_q   <= '0;
      cwren_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      kidx_q  <= kidx_d;
      ph_q    <= ph_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      saddr_q <= saddr_d;
      sin_q   <= sin_d;
      swren_q <= swren_d;
      paddr_q <= paddr_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      cwren_q <= cwren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // next-state: each step registers the memory request it issues; reads are
  // consumed two steps later (address register + RAM latency)
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    kidx_d  = kidx_q;
    ph_d    = ph_q;
    si_d    = si_q;
    sj_d    = sj_q;
    saddr_d = saddr_q;
    sin_d   = sin_q;
    swren_d = 1'b0;
    paddr_d = paddr_q;
    caddr_d = caddr_q;
    cin_d   = cin_q;
    cwren_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          kidx_d  = '0;
          ph_d    = '0;
          busy_d  = 1'b1;
          state_d = INIT;
        end
      end

      INIT: begin
        saddr_d = i_q;
        sin_d   = RAM_WIDTH'(i_q);
        swren_d = 1'b1;
        i_d     = i_q + 1'b1;
        if (i_q == '1) state_d = KSA;
      end

      KSA: begin
        ph_d = ph_q + 1'b1;
        case (ph_q)
          PW'(0): saddr_d = i_q;
          PW'(2): begin
            si_d    = sOut;
            j_d     = j_ksa_c;
            saddr_d = j_ksa_c;
          end
          PW'(4): begin
            sj_d    = sOut;
            saddr_d = i_q;
            sin_d   = sOut;
            swren_d = 1'b1;
          end
          KSA_LAST: begin
            saddr_d = j_q;
            sin_d   = si_q;
            swren_d = 1'b1;
            i_d     = i_q + 1'b1;
            kidx_d  = (kidx_q == KIW'(KEY_LENGTH - 1)) ? '0 : kidx_q + 1'b1;
            ph_d    = '0;
            if (i_q == '1) begin
              j_d     = '0;
              state_d = PRGA;
            end
          end
          default: ;
        endcase
      end

      PRGA: begin
        ph_d = ph_q + 1'b1;
        case (ph_q)
          PW'(0): begin
            i_d     = i_q + 1'b1;
            saddr_d = i_q + 1'b1;
          end
          PW'(2): begin
            si_d    = sOut;
            j_d     = j_prga_c;
            saddr_d = j_prga_c;
          end
          PW'(4): begin
            sj_d    = sOut;
            saddr_d = i_q;
            sin_d   = sOut;
            swren_d = 1'b1;
          end
          PW'(5): begin
            saddr_d = j_q;
            sin_d   = si_q;
            swren_d = 1'b1;
          end
          PW'(6): begin
            saddr_d = RAM_LENGTH'(si_q) + RAM_LENGTH'(sj_q);
            paddr_d = k_q[MESSAGE_LOG_LENGTH-1:0];
          end
          PRGA_LAST: begin
            caddr_d = k_q[MESSAGE_LOG_LENGTH-1:0];
            cin_d   = sOut ^ pOut;
            cwren_d = 1'b1;
            k_d     = k_q + 1'b1;
            ph_d    = '0;
            if (k_q == KCW'(MESSAGE_LENGTH - 1)) state_d = FIN;
          end
          default: ;
        endcase
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign sAddr = saddr_q;
  assign sIn   = sin_q;
  assign sWren = swren_q;
  assign pAddr = paddr_q;
  assign cAddr = caddr_q;
  assign cIn   = cin_q;
  assign cWren = cwren_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_rc4_encryptor.sv
// Directed bench for rc4_encryptor with behavioural S RAM, plaintext ROM and
// ciphertext RAM, plus a reference RC4 model for longer messages.
module tb_rc4_encryptor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] key;
  logic [7:0]  sAddr, sIn, sOut, pOut, cIn;
  logic        sWren, cWren, busy, done;
  logic [4:0]  pAddr, cAddr;

  logic [7:0]  smem [256];
  logic [7:0]  pmem [32];
  logic [7:0]  cmem [32];
  logic [7:0]  exp_c [32];
  logic [7:0]  orig_p [32];

  int total = 0;
  int bad   = 0;
  int lat, ncw, ord_err, ndone, busy_low, init_err, swr;

  always #5 clk = ~clk;

  rc4_encryptor dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key),
    .sAddr(sAddr), .sIn(sIn), .sWren(sWren), .sOut(sOut),
    .pAddr(pAddr), .pOut(pOut),
    .cAddr(cAddr), .cIn(cIn), .cWren(cWren),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (sWren) smem[sAddr] <= sIn;
    sOut <= smem[sAddr];
    pOut <= pmem[pAddr];
    if (cWren) cmem[cAddr] <= cIn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rc4_model(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t, i, j;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + s[x] + kb[x % 3];
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int n = 0; n < 32; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      exp_c[n] = pmem[n] ^ s[t];
    end
  endtask

  // Caller has set key and start=1 just after a rising edge; runs until done
  // (plus 20 cycles when extra start pulses are injected), cycle limit 3000.
  task automatic run_enc(input bit extra, input bit chk_init);
    int  cyc;
    bit  seen;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; lat = -1; ncw = 0; ord_err = 0; ndone = 0; busy_low = 0;
    swr = 0; init_err = -1; seen = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (cyc < 3000) begin
      start = (extra && (cyc == 10 || cyc == 500 || cyc == 2000)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (sWren) swr++;
      if (cWren) begin
        if (cAddr != 5'(ncw)) ord_err++;
        ncw++;
      end
      if (!seen && !busy && !done) busy_low++;
      if (chk_init && cyc == 257) begin
        init_err = 0;
        for (int x = 0; x < 256; x++) if (smem[x] != 8'(x)) init_err++;
        chk("init_swren_count", 32'(swr), 32'd256);
      end
      if (done) begin
        ndone++;
        if (!seen) begin
          lat = cyc;
          chk("busy_low_at_done", 32'(busy), 32'd0);
        end
        seen = 1'b1;
      end
      if (seen && (!extra || cyc >= lat + 20)) break;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [71:0] pt;
    logic [71:0] ct;
    int          mis;
    int          wp;

    pt = "Plaintext";
    ct = 72'hBBF316E8D940AF0AD3;

    // reset state
    reset_n = 1'b0;
    start   = 1'b0;
    key     = 24'h0;
    for (int b = 0; b < 32; b++) pmem[b] = 8'(b * 7 + 3);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({sAddr, sIn, sWren, pAddr, cAddr, cIn, cWren}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // abort mid-KSA with reset
    @(posedge clk); #1;
    key = 24'h4B6579;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (599) @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({sAddr, sIn, sWren, pAddr, cAddr, cIn, cWren, done}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    wp = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (sWren || cWren || busy) wp++;
    end
    chk("abort_quiet", 32'(wp), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // "Key" / "Plaintext" known vector, INIT snapshot, latency
    for (int b = 0; b < 9; b++) pmem[b] = pt[71 - 8*b -: 8];
    @(posedge clk); #1;
    key = 24'h4B6579;
    start = 1'b1;
    run_enc(1'b0, 1'b1);
    chk("latency", 32'(lat), 32'd2081);
    chk("init_identity_errors", 32'(init_err), 32'd0);
    chk("total_swren", 32'(swr), 32'd832);
    chk("cwren_count", 32'(ncw), 32'd32);
    chk("caddr_order", 32'(ord_err), 32'd0);
    chk("busy_gaps", 32'(busy_low), 32'd0);
    for (int b = 0; b < 9; b++) chk($sformatf("known_ct[%0d]", b), 32'(cmem[b]), 32'(ct[71 - 8*b -: 8]));
    rc4_model(24'h4B6579);
    mis = 0;
    for (int b = 0; b < 32; b++) if (cmem[b] !== exp_c[b]) mis++;
    chk("key_model_bytes", 32'(mis), 32'd0);

    // zero key, random plaintext, extra start pulses while busy
    for (int b = 0; b < 32; b++) begin
      pmem[b]   = 8'($urandom);
      orig_p[b] = pmem[b];
    end
    rc4_model(24'h000000);
    @(posedge clk); #1;
    key = 24'h000000;
    start = 1'b1;
    run_enc(1'b1, 1'b0);
    chk("extra_start_done_count", 32'(ndone), 32'd1);
    chk("extra_start_cwren", 32'(ncw), 32'd32);
    chk("extra_start_order", 32'(ord_err), 32'd0);
    chk("extra_start_latency", 32'(lat), 32'd2081);
    mis = 0;
    for (int b = 0; b < 32; b++) if (cmem[b] !== exp_c[b]) mis++;
    chk("zero_key_model_bytes", 32'(mis), 32'd0);

    // re-encrypting the ciphertext restores the plaintext
    for (int b = 0; b < 32; b++) pmem[b] = cmem[b];
    @(posedge clk); #1;
    key = 24'h000000;
    start = 1'b1;
    run_enc(1'b0, 1'b0);
    mis = 0;
    for (int b = 0; b < 32; b++) if (cmem[b] !== orig_p[b]) mis++;
    chk("roundtrip_bytes", 32'(mis), 32'd0);

    // back-to-back: start issued in the done cycle
    rc4_model(24'h0003FF);
    key = 24'h0003FF;
    start = 1'b1;
    run_enc(1'b0, 1'b0);
    chk("b2b_latency", 32'(lat), 32'd2081);
    mis = 0;
    for (int b = 0; b < 32; b++) if (cmem[b] !== exp_c[b]) mis++;
    chk("b2b_model_bytes", 32'(mis), 32'd0);

    @(posedge clk); #1;
    chk("idle_after_done", 32'({busy, done}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
